// File: rtl/hub75_scan_driver.sv
// HUB75 scan driver: per scan row it shifts pixel pairs out with sclk, blanks, latches,
// then lights the row for a programmable on-time. Optional green border: define HUB75_BORDER_EN.
module hub75_scan_driver #(
  parameter int unsigned COLS = 32,
  parameter int unsigned ROWS = 16,
  parameter int unsigned BW   = 4,
  parameter int unsigned AW   = $clog2(ROWS / 2),
  parameter int unsigned CW   = $clog2(COLS)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [BW-1:0] brightness,
  output logic [AW-1:0] rd_row,
  output logic [CW-1:0] rd_col,
  input  logic [2:0]    pix_top,
  input  logic [2:0]    pix_bot,
  output logic [5:0]    rgb,
  output logic          sclk,
  output logic          lat,
  output logic          oe,
  output logic [AW-1:0] abc,
  output logic          frame_done
);

  localparam int unsigned SR         = ROWS / 2;
  localparam int unsigned SHIFT_LAST = 2 * COLS;
  localparam int unsigned DISP_LAST  = (1 << BW) - 1;
  localparam int unsigned KW         = $clog2(2 * COLS + 1);
  localparam int unsigned NW         = (KW > BW) ? KW : BW;

  typedef enum logic [1:0] {
    S_SHIFT   = 2'd0,
    S_BLANK   = 2'd1,
    S_LATCH   = 2'd2,
    S_DISPLAY = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [NW-1:0] cnt_q, cnt_d;
  logic [AW-1:0] row_q, row_d;
  logic [BW-1:0] on_cnt_q, on_cnt_d;
  logic [5:0]    rgb_q, rgb_d;
  logic          sclk_q, sclk_d;
  logic          lat_q, lat_d;
  logic          oe_q, oe_d;
  logic [AW-1:0] abc_q, abc_d;
  logic [AW-1:0] rd_row_q, rd_row_d;
  logic [CW-1:0] rd_col_q, rd_col_d;
  logic          frame_done_q, frame_done_d;

  logic [CW-1:0] col;
  logic [2:0]    top_px, bot_px;

  // Column whose data is on pix_* during an odd SHIFT count
  assign col = CW'(cnt_q >> 1);

`ifdef HUB75_BORDER_EN
  always_comb begin
    top_px = pix_top;
    bot_px = pix_bot;
    if ((col == '0) || (col == CW'(COLS - 1)) || (row_q == '0)) top_px = 3'b010;
    if ((col == '0) || (col == CW'(COLS - 1)) || (row_q == AW'(SR - 1))) bot_px = 3'b010;
  end
`else
  always_comb begin
    top_px = pix_top;
    bot_px = pix_bot;
  end
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_SHIFT;
      cnt_q        <= '0;
      row_q        <= '0;
      on_cnt_q     <= '0;
      rgb_q        <= '0;
      sclk_q       <= 1'b0;
      lat_q        <= 1'b0;
      oe_q         <= 1'b1;
      abc_q        <= '0;
      rd_row_q     <= '0;
      rd_col_q     <= '0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      row_q        <= row_d;
      on_cnt_q     <= on_cnt_d;
      rgb_q        <= rgb_d;
      sclk_q       <= sclk_d;
      lat_q        <= lat_d;
      oe_q         <= oe_d;
      abc_q        <= abc_d;
      rd_row_q     <= rd_row_d;
      rd_col_q     <= rd_col_d;
      frame_done_q <= frame_done_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    row_d        = row_q;
    on_cnt_d     = on_cnt_q;
    rgb_d        = rgb_q;
    sclk_d       = 1'b0;
    lat_d        = 1'b0;
    oe_d         = 1'b1;
    abc_d        = abc_q;
    rd_col_d     = rd_col_q;
    frame_done_d = 1'b0;

    unique case (state_q)
      S_SHIFT: begin
        if (cnt_q == '0) begin
          rd_col_d = '0;
        end else if (cnt_q[0]) begin
          // Data for rd_col requested two counts ago is on pix_* now
          rgb_d    = {top_px, bot_px};
          rd_col_d = (col == CW'(COLS - 1)) ? col : col + CW'(1);
        end else begin
          sclk_d = 1'b1;
        end
        if (cnt_q == NW'(SHIFT_LAST)) begin
          state_d = S_BLANK;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + NW'(1);
        end
      end
      S_BLANK: begin
        abc_d   = row_q;
        state_d = S_LATCH;
      end
      S_LATCH: begin
        lat_d    = 1'b1;
        on_cnt_d = brightness;
        cnt_d    = '0;
        state_d  = S_DISPLAY;
      end
      S_DISPLAY: begin
        oe_d = (cnt_q < NW'(on_cnt_q)) ? 1'b0 : 1'b1;
        if (cnt_q == NW'(DISP_LAST)) begin
          state_d  = S_SHIFT;
          cnt_d    = '0;
          rd_col_d = '0;
          if (row_q == AW'(SR - 1)) begin
            row_d        = '0;
            frame_done_d = 1'b1;
          end else begin
            row_d = row_q + AW'(1);
          end
        end else begin
          cnt_d = cnt_q + NW'(1);
        end
      end
      default: state_d = S_SHIFT;
    endcase

    // Pixel source row follows the row counter so it is ready at SHIFT count 0
    rd_row_d = row_d;
  end

  assign rgb        = rgb_q;
  assign sclk       = sclk_q;
  assign lat        = lat_q;
  assign oe         = oe_q;
  assign abc        = abc_q;
  assign rd_row     = rd_row_q;
  assign rd_col     = rd_col_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_hub75_scan_driver.sv
// Scoreboard bench for hub75_scan_driver (COLS=32, ROWS=16, BW=4).
module tb_hub75_scan_driver;

  localparam int COLS   = 32;
  localparam int ROWS   = 16;
  localparam int BW     = 4;
  localparam int SR     = ROWS / 2;
  localparam int AW     = 3;
  localparam int CW     = 5;
  localparam int PERIOD = 2 * COLS + 3 + (1 << BW);

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [BW-1:0] brightness = '0;
  logic [AW-1:0] rd_row;
  logic [CW-1:0] rd_col;
  logic [2:0]    pix_top = 3'b000;
  logic [2:0]    pix_bot = 3'b000;
  logic [5:0]    rgb;
  logic          sclk, lat, oe, frame_done;
  logic [AW-1:0] abc;

  int n_checks = 0;
  int n_fail   = 0;
  int src_mode = 0;
  int next_row = 0;
  int cur_on   = 0;
  logic [5:0] exp_q[$];

  hub75_scan_driver #(.COLS(COLS), .ROWS(ROWS), .BW(BW)) dut (
    .clk(clk), .reset(reset), .brightness(brightness),
    .rd_row(rd_row), .rd_col(rd_col), .pix_top(pix_top), .pix_bot(pix_bot),
    .rgb(rgb), .sclk(sclk), .lat(lat), .oe(oe), .abc(abc), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  // Synchronous pixel source, one cycle latency
  always @(posedge clk) begin
    pix_top <= (src_mode == 0) ? {rd_col[0], 2'b01} : 3'b000;
    pix_bot <= (src_mode == 0) ? 3'b100 : 3'b000;
  end

  function automatic logic [5:0] exp_pix(input int row, input int col);
    logic [2:0] t, b;
    logic [CW-1:0] c;
    c = CW'(col);
    t = (src_mode == 0) ? {c[0], 2'b01} : 3'b000;
    b = (src_mode == 0) ? 3'b100 : 3'b000;
`ifdef HUB75_BORDER_EN
    if (col == 0 || col == COLS - 1 || row == 0) t = 3'b010;
    if (col == 0 || col == COLS - 1 || row == SR - 1) b = 3'b010;
`endif
    return {t, b};
  endfunction

  task automatic push_row(input int row);
    for (int c = 0; c < COLS; c++) exp_q.push_back(exp_pix(row, c));
  endtask

  // Follows the first row after reset release up to its latch pulse
  task automatic shift_first_row();
    int rises = 0;
    int cyc = 0;
    bit done = 0;
    logic prev = 1'b0;
    logic [5:0] e;
    push_row(0);
    while (!done && cyc < 100) begin
      @(negedge clk);
      cyc++;
      if (sclk && !prev) begin
        rises++;
        if (rises == 1) begin
          n_checks++;
          if (cyc != 3) begin n_fail++; $display("FAIL first_rise_latency: got %0d cycles expected 3", cyc); end
        end
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++; $display("FAIL first_row_extra_rise: got rise %0d expected none", rises);
        end else begin
          e = exp_q.pop_front();
          if (rgb !== e) begin n_fail++; $display("FAIL first_row_rgb: col %0d got %b expected %b", rises - 1, rgb, e); end
        end
        n_checks++;
        if (rd_row !== 3'd0) begin n_fail++; $display("FAIL first_row_rd_row: got %0d expected 0", rd_row); end
      end
      if (lat) done = 1;
      prev = sclk;
    end
    n_checks++;
    if (!done) begin n_fail++; $display("FAIL first_row_lat_timeout: got no lat expected lat within 100 cycles"); end
    n_checks++;
    if (rises != COLS) begin n_fail++; $display("FAIL first_row_rises: got %0d expected %0d", rises, COLS); end
    n_checks++;
    if (abc !== 3'd0) begin n_fail++; $display("FAIL first_row_abc: got %0d expected 0", abc); end
    exp_q.delete();
    next_row = 1;
    cur_on = int'(brightness);
  endtask

  // From one lat sample to the next: display of the latched row, shift of next_row
  task automatic observe_window(input int chg_cyc, input int chg_val);
    int cyc = 0, lows = 0, falls = 0, rises = 0, fd = 0, abc_bad = 0;
    int row;
    bit done = 0;
    logic prev_s = 1'b0;
    logic prev_oe;
    logic [AW-1:0] prev_abc;
    logic [5:0] e;
    row = next_row;
    prev_oe = oe;
    prev_abc = abc;
    push_row(row);
    while (!done && cyc < PERIOD + 10) begin
      @(negedge clk);
      cyc++;
      if (cyc == chg_cyc) brightness = BW'(chg_val);
      if (!oe) lows++;
      if (!oe && prev_oe) falls++;
      if (frame_done) fd++;
      if (abc !== prev_abc && !oe) abc_bad++;
      if (sclk && !prev_s) begin
        rises++;
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++; $display("FAIL shift_extra_rise: row %0d got rise %0d expected none", row, rises);
        end else begin
          e = exp_q.pop_front();
          if (rgb !== e) begin n_fail++; $display("FAIL shift_rgb: row %0d col %0d got %b expected %b", row, rises - 1, rgb, e); end
        end
        n_checks++;
        if (rd_row !== AW'(row)) begin n_fail++; $display("FAIL shift_rd_row: got %0d expected %0d", rd_row, row); end
      end
      if (lat) begin
        done = 1;
        n_checks++;
        if (!oe) begin n_fail++; $display("FAIL lat_with_oe_low: got oe=%b expected 1", oe); end
      end
      prev_s = sclk;
      prev_oe = oe;
      prev_abc = abc;
    end
    n_checks++;
    if (!done) begin n_fail++; $display("FAIL window_lat_timeout: row %0d got no lat expected lat", row); end
    n_checks++;
    if (cyc != PERIOD) begin n_fail++; $display("FAIL row_period: got %0d expected %0d", cyc, PERIOD); end
    n_checks++;
    if (lows != cur_on) begin n_fail++; $display("FAIL oe_on_cycles: got %0d expected %0d", lows, cur_on); end
    n_checks++;
    if (falls != ((cur_on > 0) ? 1 : 0)) begin n_fail++; $display("FAIL oe_runs: got %0d expected %0d", falls, (cur_on > 0) ? 1 : 0); end
    n_checks++;
    if (rises != COLS) begin n_fail++; $display("FAIL sclk_rises: row %0d got %0d expected %0d", row, rises, COLS); end
    n_checks++;
    if (fd != ((row == 0) ? 1 : 0)) begin n_fail++; $display("FAIL frame_done_count: row %0d got %0d expected %0d", row, fd, (row == 0) ? 1 : 0); end
    n_checks++;
    if (abc !== AW'(row)) begin n_fail++; $display("FAIL abc_at_lat: got %0d expected %0d", abc, row); end
    n_checks++;
    if (abc_bad != 0) begin n_fail++; $display("FAIL abc_change_while_lit: got %0d changes expected 0", abc_bad); end
    exp_q.delete();
    cur_on = int'(brightness);
    next_row = (row + 1) % SR;
  endtask

  task automatic check_reset_values(input string tag);
    n_checks++;
    if (rgb !== 6'd0 || sclk !== 1'b0 || lat !== 1'b0 || oe !== 1'b1 || frame_done !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_outputs: got rgb=%b sclk=%b lat=%b oe=%b fd=%b expected rgb=0 sclk=0 lat=0 oe=1 fd=0",
               tag, rgb, sclk, lat, oe, frame_done);
    end
    n_checks++;
    if (abc !== 3'd0 || rd_row !== 3'd0 || rd_col !== 5'd0) begin
      n_fail++;
      $display("FAIL %s_addr: got abc=%0d rd_row=%0d rd_col=%0d expected 0 0 0", tag, abc, rd_row, rd_col);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    brightness = 4'd15;
    src_mode = 0;
    repeat (3) @(negedge clk);
    check_reset_values("reset");
    reset = 1'b0;
    shift_first_row();
  endtask

  task automatic test_scan();
    repeat (SR) observe_window(-1, 0);
  endtask

  task automatic test_brightness();
    brightness = 4'd0;
    observe_window(-1, 0);
    repeat (SR) observe_window(-1, 0);
    brightness = 4'd15;
    observe_window(-1, 0);
    observe_window(5, 6);
    observe_window(-1, 0);
    brightness = 4'd15;
    observe_window(-1, 0);
  endtask

  task automatic test_border();
    src_mode = 1;
    repeat (SR + 1) observe_window(-1, 0);
    src_mode = 0;
  endtask

  task automatic test_reset_mid_shift();
    int rises = 0, cyc = 0;
    logic prev = 1'b0;
    while (next_row != 3) observe_window(-1, 0);
    while (rises < 10 && cyc < PERIOD + 10) begin
      @(negedge clk);
      cyc++;
      if (sclk && !prev) rises++;
      prev = sclk;
    end
    n_checks++;
    if (rises != 10) begin n_fail++; $display("FAIL mid_reset_reach: got %0d rises expected 10", rises); end
    @(negedge clk);
    n_checks++;
    if (rd_row !== 3'd3) begin n_fail++; $display("FAIL mid_reset_pre_row: got %0d expected 3", rd_row); end
    reset = 1'b1;
    #1;
    check_reset_values("mid_reset");
    repeat (2) @(negedge clk);
    check_reset_values("mid_reset_hold");
    reset = 1'b0;
    shift_first_row();
    observe_window(-1, 0);
  endtask

  initial begin
    test_reset();
    test_scan();
    test_brightness();
    test_border();
    test_reset_mid_shift();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
